// File: rtl/enc4b_rd_if.sv
// Bundles the symbol-in / code-out handshake of the running-disparity 8b/10b back end.
//   in_valid, in_ready    : upstream handshake
//   abcdei                : 6b sub-block already chosen for the current PD1S6
//   data_buffer           : {S, K, H, G, F} classification word
//   PD1S6                 : running disparity before the 6b sub-block (1 = positive)
//   dout                  : {a,b,c,d,e,i,f,g,h,j}, a is the MSB
//   out_valid, out_ready  : downstream handshake
//   code_err              : illegal 6b disparity for the current running disparity
// slave is the encoder side; master is the surrounding environment.
interface enc4b_rd_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] abcdei;
  logic [4:0] data_buffer;
  logic       PD1S6;
  logic [9:0] dout;
  logic       out_valid;
  logic       out_ready;
  logic       code_err;

  modport slave (
    input  in_valid,
    input  abcdei,
    input  data_buffer,
    input  out_ready,
    output in_ready,
    output PD1S6,
    output dout,
    output out_valid,
    output code_err
  );

  modport master (
    output in_valid,
    output abcdei,
    output data_buffer,
    output out_ready,
    input  in_ready,
    input  PD1S6,
    input  dout,
    input  out_valid,
    input  code_err
  );
endinterface

// File: rtl/enc4b_rd.sv
// 3b/4b stage of an 8b/10b encoder with running-disparity tracking and a one-entry output
// register.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : enc4b_rd_if.slave (symbol in, registered 10b code out, PD1S6 feedback)
// The upstream 5b/6b stage picks abcdei using PD1S6; this block checks that choice, derives
// the disparity after the 6b sub-block (RD6), picks fghj and advances the running disparity.
module enc4b_rd (
  input logic      clk,
  input logic      reset,
  enc4b_rd_if.slave bus
);

  logic       rd_q;
  logic [9:0] dout_q;
  logic       out_valid_q;
  logic       code_err_q;

  logic       accept;
  logic [2:0] n6;
  logic [2:0] n4;
  logic       rd6;
  logic       err6;
  logic       s_bit;
  logic       k_bit;
  logic [2:0] hgf;
  logic [3:0] fghj_base;
  logic [3:0] fghj;
  logic       rd_next;

  assign s_bit = bus.data_buffer[4];
  assign k_bit = bus.data_buffer[3];
  assign hgf   = bus.data_buffer[2:0];

  // Single register stage: a consumed or empty slot can take a new symbol the same cycle.
  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    n6 = '0;
    for (int i = 0; i < 6; i++) n6 = n6 + {2'b00, bus.abcdei[i]};
  end

  // Disparity after the 6b sub-block; illegal weights leave RD untouched and flag an error.
  always_comb begin
    rd6  = rd_q;
    err6 = 1'b0;
    if (n6 == 3'd3) begin
      rd6 = rd_q;
    end else if (n6 == 3'd4 && !rd_q) begin
      rd6 = 1'b1;
    end else if (n6 == 3'd2 && rd_q) begin
      rd6 = 1'b0;
    end else begin
      err6 = 1'b1;
    end
  end

  // fghj as seen with RD6 negative.
  always_comb begin
    fghj_base = 4'b0000;
    unique case (hgf)
      3'b000: fghj_base = 4'b1011;
      3'b001: fghj_base = 4'b1001;
      3'b010: fghj_base = 4'b0101;
      3'b011: fghj_base = 4'b1100;
      3'b100: fghj_base = 4'b1101;
      3'b101: fghj_base = 4'b1010;
      3'b110: fghj_base = 4'b0110;
      3'b111: fghj_base = 4'b1110;
      default: fghj_base = 4'b0000;
    endcase
  end

  always_comb begin
    fghj = fghj_base;
    if (hgf == 3'b111 && (s_bit || k_bit)) begin
      // Alternate x.7 avoids a run of five in the combined code.
      fghj = rd6 ? 4'b1000 : 4'b0111;
    end else if (rd6 && (hgf == 3'b000 || hgf == 3'b100 || hgf == 3'b111 ||
                         hgf == 3'b011)) begin
      fghj = ~fghj_base;
    end else if (k_bit && !rd6 && (hgf == 3'b001 || hgf == 3'b010 || hgf == 3'b101 ||
                                   hgf == 3'b110)) begin
      // Control characters use the opposite polarity of the neutral codes.
      fghj = ~fghj_base;
    end
  end

  always_comb begin
    n4 = '0;
    for (int i = 0; i < 4; i++) n4 = n4 + {2'b00, fghj[i]};
    rd_next = (n4 != 3'd2) ? ~rd6 : rd6;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q        <= 1'b0;
      dout_q      <= 10'b0;
      out_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
    end else if (accept) begin
      rd_q        <= rd_next;
      dout_q      <= {bus.abcdei, fghj};
      out_valid_q <= 1'b1;
      code_err_q  <= err6;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.PD1S6     = rd_q;
  assign bus.dout      = dout_q;
  assign bus.out_valid = out_valid_q;
  assign bus.code_err  = code_err_q;

endmodule

// File: tb/tb_enc4b_rd.sv
module tb_enc4b_rd;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  enc4b_rd_if bus ();

  enc4b_rd u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Present one symbol, let it be accepted at the next edge, then sample #1 later.
  task automatic send(input logic [5:0] a6, input logic [4:0] db);
    bus.in_valid    = 1'b1;
    bus.abcdei      = a6;
    bus.data_buffer = db;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [9:0] d, input logic err,
                         input logic pd);
    chk({tag, ".dout"}, bus.dout, d);
    chk({tag, ".err"}, {9'b0, bus.code_err}, {9'b0, err});
    chk({tag, ".pd"}, {9'b0, bus.PD1S6}, {9'b0, pd});
    chk({tag, ".ov"}, {9'b0, bus.out_valid}, 10'd1);
  endtask

  initial begin
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.abcdei      = '0;
    bus.data_buffer = '0;
    bus.out_ready   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst.ov", {9'b0, bus.out_valid}, 10'd0);
    chk("rst.dout", bus.dout, 10'b0);
    chk("rst.err", {9'b0, bus.code_err}, 10'd0);
    chk("rst.pd", {9'b0, bus.PD1S6}, 10'd0);
    chk("rst.ir", {9'b0, bus.in_ready}, 10'd1);

    // D.21.5 at RD-
    send(6'b101010, 5'b00101);
    chk_out("d21_5", 10'b1010101010, 1'b0, 1'b0);
    // K.28.5 at RD- then D.x.0 at RD+ (back to back)
    send(6'b001111, 5'b01101);
    chk_out("k28_5", 10'b0011111010, 1'b0, 1'b1);
    send(6'b101010, 5'b00000);
    chk_out("dx_0p", 10'b1010100100, 1'b0, 1'b0);
    // D.17.7 with S=1 -> A7
    send(6'b100011, 5'b10111);
    chk_out("d17_7a", 10'b1000110111, 1'b0, 1'b1);
    send(6'b101010, 5'b00000);
    chk_out("dx_0p2", 10'b1010100100, 1'b0, 1'b0);
    // Weight-2 at RD- is illegal: RD6 stays 0, fghj from table, RD flips on fghj weight 3
    send(6'b110000, 5'b00000);
    chk_out("err_n2", 10'b1100001011, 1'b1, 1'b1);
    // Weight-4 at RD+ is illegal: RD6 stays 1, neutral fghj keeps RD
    send(6'b111100, 5'b00001);
    chk_out("err_n4", 10'b1111001001, 1'b1, 1'b1);
    // K with RD6=0 on a neutral code -> complement
    send(6'b100100, 5'b01010);
    chk_out("k_x_2", 10'b1001001010, 1'b0, 1'b0);
    // K.28.7 at RD- -> RD6=1, A7 form 1000
    send(6'b001111, 5'b01111);
    chk_out("k28_7", 10'b0011111000, 1'b0, 1'b0);

    // Back-pressure: hold a pending code, present the next symbol for 3 cycles
    @(posedge clk);
    #1;
    chk("idle.ov", {9'b0, bus.out_valid}, 10'd0);
    bus.out_ready = 1'b0;
    send(6'b001111, 5'b01101);
    chk_out("stall0", 10'b0011111010, 1'b0, 1'b1);
    bus.in_valid    = 1'b1;
    bus.abcdei      = 6'b101010;
    bus.data_buffer = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.ir", {9'b0, bus.in_ready}, 10'd0);
      @(posedge clk);
      #1;
      chk_out("stall", 10'b0011111010, 1'b0, 1'b1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("rel.ir", {9'b0, bus.in_ready}, 10'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk_out("rel", 10'b1010100100, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("nodup.ov", {9'b0, bus.out_valid}, 10'd0);
    chk("nodup.pd", {9'b0, bus.PD1S6}, 10'd0);

    // Reset while a code is pending, with a competing accept
    bus.out_ready = 1'b0;
    send(6'b001111, 5'b01101);
    chk_out("pre_rst", 10'b0011111010, 1'b0, 1'b1);
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.abcdei      = 6'b001111;
    bus.data_buffer = 5'b01101;
    reset           = 1'b1;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    chk("mrst.ov", {9'b0, bus.out_valid}, 10'd0);
    chk("mrst.pd", {9'b0, bus.PD1S6}, 10'd0);
    chk("mrst.dout", bus.dout, 10'b0);
    chk("mrst.err", {9'b0, bus.code_err}, 10'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/enc4b_rd.md
ENC4B_RD -- requirements
Module: enc4b_rd

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  upstream symbol present.
REQ-004 in_ready  output  1  block accepts the symbol this cycle.
REQ-005 abcdei  input  6  6b sub-block, already chosen by the upstream 5b/6b stage for the current PD1S6.
REQ-006 data_buffer  input  5  {S, K, H, G, F}, the 3b/4b classification word.
REQ-007 PD1S6  output  1  running disparity before the 6b sub-block (1 = positive), fed back upstream.
REQ-008 dout  output  10  registered code {a,b,c,d,e,i,f,g,h,j}, with a as MSB.
REQ-009 out_valid  output  1  dout holds an unconsumed code.
REQ-010 out_ready  input  1  downstream consumes dout.
REQ-011 code_err  output  1  registered alongside dout; set when the 6b disparity is illegal.

Function
REQ-012 Accept when in_valid & in_ready; in_ready = ~out_valid | out_ready (single-stage skid-free register).
REQ-013 Latency is 1 cycle: an accept in cycle N gives dout/out_valid/code_err in cycle N+1.
REQ-014 Hold dout, code_err and out_valid stable while out_valid & ~out_ready.
REQ-015 Clear out_valid after a cycle with out_ready & ~accept; keep out_valid=1 on simultaneous consume and accept.
REQ-016 Hold the RD register; PD1S6 = RD combinationally from the register; RD updates only on accept.
REQ-017 Compute n6 = ones count of abcdei.
  - n6 = 3: neutral, RD6 = RD.
  - n6 = 4 with RD = 0: RD6 = 1.
  - n6 = 2 with RD = 1: RD6 = 0.
REQ-018 Set code_err for every other abcdei, i.e. n6 outside {2,3,4}, n6 = 4 with RD = 1, or n6 = 2 with RD = 0; RD6 = RD in the error case.
REQ-019 Encode fghj from HGF with RD6 = 0 using the following codes; with RD6 = 1, the flipping codes (000, 100, 111) and code 011 are bitwise complemented.
  - 000 -> 1011
  - 001 -> 1001
  - 010 -> 0101
  - 011 -> 1100
  - 100 -> 1101
  - 101 -> 1010
  - 110 -> 0110
  - 111 -> 1110
REQ-020 For HGF = 111 with S | K, use the A7 code: 0111 when RD6 = 0, 1000 when RD6 = 1.
REQ-021 For K = 1 and HGF in {001, 010, 101, 110} with RD6 = 0, output the complement of the REQ-019 code; with RD6 = 1, output the code unchanged.
REQ-022 Set RD_next = ~RD6 if the ones count of fghj ≠ 2, else RD_next = RD6; load RD_next into RD on accept.
REQ-023 When no accept occurs, leave RD and PD1S6 unchanged regardless of out_ready.
REQ-024 Do not check legality of K combinations; any data_buffer value is encoded per REQ-019..021.

Reset
REQ-025 When reset is high at a clock edge:
  - RD = 0 (negative);
  - out_valid = 0, dout = 10'b0, code_err = 0;
  - in_ready = 1 in the following cycle.
REQ-026 Reset mid-transfer discards a pending dout with no handshake; reset dominates a simultaneous accept.

Verification
REQ-027 The bench shall cover the following directed scenarios.
  - After reset: PD1S6 = 0. abcdei = 101010, data_buffer = 5'b00101 (D.21.5) -> next cycle dout = 1010101010, code_err = 0, PD1S6 = 0.
  - RD = 0: abcdei = 001111, data_buffer = 5'b01101 (K.28.5) -> dout = 0011111010, PD1S6 = 1. Then abcdei = 101010, data_buffer = 5'b00000 -> dout = 1010100100, PD1S6 = 0.
  - RD = 0: abcdei = 100011, data_buffer = 5'b10111 (D.17.7, S = 1) -> dout = 1000110111, PD1S6 = 1.
  - RD = 0: abcdei = 110000 -> code_err = 1, RD6 = 0, dout carries 110000 plus the REQ-019 fghj.
  - out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, dout stable, PD1S6 frozen. Then out_ready = 1 -> a new symbol accepted the same cycle, no symbol lost or duplicated.
  - Reset asserted while out_valid = 1 and out_ready = 0 -> next cycle out_valid = 0, PD1S6 = 0.
